// File: rtl/program_counter_pkg.sv
// ---------------------------------------------------------------------------
// program_counter_pkg
//
// Definitions shared by the fetch-side program counter and its sub-blocks:
//   - PC_WIDTH     : address width of the 16-bit CPU
//   - pc_state_e   : fetch state machine encoding (IDLE / FETCH / HALT)
//   - ptr_width()  : width of the return-stack pointer, which must be able to
//                    hold every value 0..depth inclusive
// ---------------------------------------------------------------------------
package program_counter_pkg;

  localparam int PC_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  // The pointer counts entries (0..depth), so it needs one more bit than an
  // index into the array.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Index width into the stack array; never zero so a depth-1 stack still
  // gets a legal one-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/program_counter_increment.sv
// ---------------------------------------------------------------------------
// OptimalIncrement
//
// Gate-level +1 incrementer: a ripple chain of half adders with the carry-in
// tied high. Wraps modulo 2^WIDTH (all-ones + 1 = 0); the carry out of the
// top bit is not produced because nothing needs it.
//
// Ports:
//   value        in  WIDTH  operand
//   incremented  out WIDTH  value + 1 (mod 2^WIDTH)
// ---------------------------------------------------------------------------
module OptimalIncrement
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] incremented
);

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign incremented[i] = value[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = value[i] & carry[i];
    end
  end

endmodule

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// Fetch-side program counter for the 16-bit CPU. Holds the current
// instruction address, presents it to instruction memory over a valid/ready
// handshake and, on every accepted fetch, chooses the next address from
// halt / return / call / jump / increment (in that priority). A small
// return-address stack backs call and return.
//
// Parameters:
//   WIDTH        address width (only 16 is supported)
//   RESET_ADDR   pc value after reset
//   STACK_DEPTH  return-stack entries (>= 1)
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   run          in   1      level enable for fetching
//   fetch_valid  out  1      fetch_addr holds a request
//   fetch_addr   out  WIDTH  address being fetched (always equals pc)
//   fetch_ready  in   1      memory accepts the request
//   jump_en      in   1      next pc = jump_target
//   call_en      in   1      push pc+1, next pc = jump_target
//   ret_en       in   1      next pc = popped stack top
//   halt_en      in   1      next pc = pc+1, then stop fetching
//   jump_target  in   WIDTH  jump/call destination
//   pc           out  WIDTH  current program counter
//   halted       out  1      state is HALT
//   stack_full   out  1      stack holds STACK_DEPTH entries
//   stack_empty  out  1      stack holds no entries
//   stack_err    out  1      sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter int               STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_addr,
  input  logic             fetch_ready,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             halt_en,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic             halted,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int               PTR_W       = ptr_width(STACK_DEPTH);
  localparam int               IDX_W       = idx_width(STACK_DEPTH);
  localparam int               ARRAY_SIZE  = 1 << IDX_W;
  localparam logic [PTR_W-1:0] DEPTH_COUNT = PTR_W'(STACK_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

  pc_state_e        state, state_next;
  logic [WIDTH-1:0] pc_q, pc_next, pc_inc;
  logic [PTR_W-1:0] sp_q, sp_next;
  logic             err_q, err_next;
  logic             valid_q, halted_q, full_q, empty_q;

  logic [WIDTH-1:0] stack_mem [ARRAY_SIZE];
  logic             push_en;
  logic [IDX_W-1:0] push_idx, top_idx;

  // One incrementer feeds both the sequential path and the call return
  // address, so pc+1 is computed exactly once.
  OptimalIncrement #(
    .WIDTH (WIDTH)
  ) u_increment (
    .value       (pc_q),
    .incremented (pc_inc)
  );

  // sp_q counts entries: the next free slot is sp_q and the top is sp_q-1.
  // Truncation is safe because a push never happens when full and a pop
  // never happens when empty.
  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - PTR_ONE);

  // Next-state / next-pc selection. Controls are only looked at on an accept
  // (FETCH with fetch_ready); once in FETCH the request is held until memory
  // takes it, so a run drop before the accept has no effect.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    sp_next    = sp_q;
    err_next   = err_q;
    push_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (fetch_ready) begin
          if (halt_en) begin
            // Halt outranks everything and leaves the stack alone.
            state_next = ST_HALT;
            pc_next    = pc_inc;
          end else begin
            state_next = run ? ST_FETCH : ST_IDLE;
            if (ret_en) begin
              // Underflow falls through to a plain increment.
              if (empty_q) begin
                pc_next  = pc_inc;
                err_next = 1'b1;
              end else begin
                pc_next = stack_mem[top_idx];
                sp_next = sp_q - PTR_ONE;
              end
            end else if (call_en) begin
              // Overflow still jumps; only the push is dropped.
              pc_next = jump_target;
              if (full_q) begin
                err_next = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_next = sp_q + PTR_ONE;
              end
            end else if (jump_en) begin
              pc_next = jump_target;
            end else begin
              pc_next = pc_inc;
            end
          end
        end
      end

      ST_HALT: begin
        if (run && !halt_en) begin
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, pc, stack pointer and the output flags. The flags are computed
  // from the next-state values so every output comes straight from a flop
  // and updates in the same cycle as pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc_q     <= RESET_ADDR;
      sp_q     <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      state    <= state_next;
      pc_q     <= pc_next;
      sp_q     <= sp_next;
      err_q    <= err_next;
      valid_q  <= (state_next == ST_FETCH);
      halted_q <= (state_next == ST_HALT);
      full_q   <= (sp_next == DEPTH_COUNT);
      empty_q  <= (sp_next == '0);
    end
  end

  // Return-address storage. Contents need no reset: the pointer alone
  // decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign fetch_valid = valid_q;
  assign fetch_addr  = pc_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign stack_err   = err_q;

endmodule
